ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; the send direction of the keyboard link whose receive path already exists.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_host_tx_if.sv | 27 ++
 rtl/ps2_sync_edge.sv | 35 +++
 rtl/ps2_host_tx.sv | 170 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: transmitter state encoding, frame length, common
// command bytes and small helpers. Imported by the transmitter, its interface
// users and (later) the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  // data[7:0] + parity + stop; the start bit is produced by request-to-send
  localparam int PS2_FRAME_BITS = 10;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // Frame as shifted out LSB first: {stop, odd parity, data}
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

  function automatic int ps2_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a controller and the PS/2 transmitter.
//   tx_data  : command byte
//   tx_valid : request, accepted when tx_valid & tx_ready
//   tx_ready : transmitter idle and able to accept
//   busy     : transmitter in flight (receiver discards frames meanwhile)
//   done/err : one-cycle completion / failure pulses
// master = command issuer, slave = transmitter.
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, err
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an asynchronous PS/2 pin plus a one-cycle pulse
// on a synchronised 1->0 transition.
//   clk   : system clock
//   rst   : synchronous active-high reset (flops go to the idle-high level)
//   din   : asynchronous pin
//   level : synchronised pin level
//   fall  : one-cycle pulse when level goes 1->0
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta   <= din;
      sync_q <= meta;
      prev_q <= sync_q;
    end
  end

  assign level = sync_q;
  assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte over the
// open-drain clock/data pair: inhibit the clock, request-to-send, shift the
// frame out on device clock falls, then check the device ACK.
//   clk, rst    : system clock, synchronous active-high reset
//   tx          : command handshake (slave side)
//   ps2_clk_i   : PS/2 clock pin (async)
//   ps2_data_i  : PS/2 data pin (async)
//   ps2_clk_oe  : 1 pulls the clock line low
//   ps2_data_oe : 1 pulls the data line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10_000,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  ps2_host_tx_if.slave tx,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
);

  localparam int CNT_W = $clog2(ps2_max(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  ps2_tx_state_t               state, state_n;
  logic [CNT_W-1:0]            cyc_cnt, cyc_cnt_n;
  logic [3:0]                  bit_cnt, bit_cnt_n;
  logic [PS2_FRAME_BITS-1:0]   frame, frame_n;
  logic                        data_oe_q, data_oe_n;
  logic                        done_c, err_c;
  logic                        timed, timeout;

  logic clk_level, clk_fall;
  logic data_level, unused_data_fall;

  ps2_sync_edge u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (ps2_clk_i),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (ps2_data_i),
    .level (data_level),
    .fall  (unused_data_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      data_oe_q <= 1'b0;
    end else begin
      state     <= state_n;
      cyc_cnt   <= cyc_cnt_n;
      bit_cnt   <= bit_cnt_n;
      data_oe_q <= data_oe_n;
    end
  end

  // Frame is pure data; it is always reloaded on accept.
  always_ff @(posedge clk) begin
    frame <= frame_n;
  end

  // The response timeout covers everything after the clock is released.
  assign timed   = (state == RTS) || (state == SHIFT) ||
                   (state == ACK) || (state == WAIT_IDLE);
  assign timeout = timed && (cyc_cnt == TO_LIMIT);

  always_comb begin
    state_n   = state;
    cyc_cnt_n = cyc_cnt;
    bit_cnt_n = bit_cnt;
    frame_n   = frame;
    data_oe_n = data_oe_q;
    done_c    = 1'b0;
    err_c     = 1'b0;

    if (timeout) begin
      // Takes priority over a clock fall in the same cycle.
      err_c     = 1'b1;
      data_oe_n = 1'b0;
      state_n   = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          data_oe_n = 1'b0;
          if (tx.tx_valid) begin
            frame_n   = ps2_frame(tx.tx_data);
            bit_cnt_n = '0;
            cyc_cnt_n = '0;
            state_n   = INHIBIT;
          end
        end
        INHIBIT: begin
          if (cyc_cnt == INH_LAST) begin
            cyc_cnt_n = '0;
            state_n   = RTS;
          end else begin
            cyc_cnt_n = sat_inc(cyc_cnt);
          end
        end
        RTS: begin
          // Data stays low into SHIFT: that low level is the start bit.
          cyc_cnt_n = sat_inc(cyc_cnt);
          data_oe_n = 1'b1;
          state_n   = SHIFT;
        end
        SHIFT: begin
          cyc_cnt_n = sat_inc(cyc_cnt);
          if (clk_fall) begin
            data_oe_n = ~frame[0];
            frame_n   = {1'b0, frame[PS2_FRAME_BITS-1:1]};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) begin
              state_n = ACK;
            end
          end
        end
        ACK: begin
          cyc_cnt_n = sat_inc(cyc_cnt);
          data_oe_n = 1'b0;
          if (clk_fall) begin
            if (data_level) begin
              err_c   = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          cyc_cnt_n = sat_inc(cyc_cnt);
          if (clk_level && data_level) begin
            done_c  = 1'b1;
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign tx.tx_ready = (state == IDLE);
  assign tx.busy     = (state != IDLE);
  // A reset cycle must never look like a completed or failed frame.
  assign tx.done     = done_c & ~rst;
  assign tx.err      = err_c & ~rst;

  assign ps2_clk_oe  = (state == INHIBIT);
  assign ps2_data_oe = (state == RTS) || ((state == SHIFT) && data_oe_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: models an open-drain PS/2 device that clocks the
// frame in, samples data on the clock rise, and ACKs (or not) on the 11th
// clock. Timing parameters are scaled down to keep the run short.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 100;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  localparam int M_OK    = 0;
  localparam int M_NOCLK = 1;
  localparam int M_NACK  = 2;
  localparam int M_RST   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_pin, ps2_data_pin;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit pulse_q = 1'b0;

  assign ps2_clk_pin  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_pin = ~ps2_data_oe & dev_data;

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx          (tx_if),
    .ps2_clk_i   (ps2_clk_pin),
    .ps2_data_i  (ps2_data_pin),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse properties: exclusive, one cycle wide, IDLE right after.
  always @(negedge clk) begin
    if (pulse_q) begin
      check("pulse_width", {31'd0, tx_if.done | tx_if.err}, 0);
      check("ready_after_pulse", {31'd0, tx_if.tx_ready}, 1);
    end
    if (tx_if.done || tx_if.err) begin
      check("done_err_exclusive", {31'd0, tx_if.done & tx_if.err}, 0);
    end
    if (tx_if.done) done_cnt++;
    if (tx_if.err) err_cnt++;
    pulse_q = tx_if.done | tx_if.err;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    while (!tx_if.tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", {31'd0, tx_if.tx_ready}, 1);
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    check("busy_after_accept", {31'd0, tx_if.busy}, 1);
    check("ready_low_after_accept", {31'd0, tx_if.tx_ready}, 0);
  endtask

  task automatic device(input logic [7:0] b, input logic par, input int mode, input bit drop_valid);
    int n;
    int rts_cyc;
    int d0, e0;
    logic [9:0] rx;
    rx = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    n = 0;
    while (!ps2_clk_oe && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_start", {31'd0, ps2_clk_oe}, 1);
    if (drop_valid) tx_if.tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < INH + 50) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_len", n, INH);
    check("rts_data_oe", {31'd0, ps2_data_oe}, 1);
    rts_cyc = cyc;

    if (mode == M_NOCLK) begin
      n = 0;
      while (!tx_if.err && n < TO + 50) begin
        @(negedge clk);
        n++;
      end
      check("timeout_err", {31'd0, tx_if.err}, 1);
      check("timeout_cycles", cyc - rts_cyc, TO);
      check("timeout_no_done", {31'd0, tx_if.done}, 0);
      @(negedge clk);
      check("timeout_clk_oe", {31'd0, ps2_clk_oe}, 0);
      check("timeout_data_oe", {31'd0, ps2_data_oe}, 0);
      check("timeout_ready", {31'd0, tx_if.tx_ready}, 1);
      return;
    end

    wait_cycles(4);
    check("start_bit", {31'd0, ps2_data_pin}, 0);

    for (int i = 0; i < 10; i++) begin
      if (mode == M_RST && i == 4) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
        check("rst_data_oe", {31'd0, ps2_data_oe}, 0);
        check("rst_busy", {31'd0, tx_if.busy}, 0);
        check("rst_ready", {31'd0, tx_if.tx_ready}, 1);
        wait_cycles(5);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_err", err_cnt - e0, 0);
        return;
      end
      dev_clk = 1'b0;
      wait_cycles(HALF);
      dev_clk = 1'b1;
      rx[i] = ps2_data_pin;
      if (i == 5) begin
        check("ready_low_in_frame", {31'd0, tx_if.tx_ready}, 0);
        check("clk_oe_low_in_shift", {31'd0, ps2_clk_oe}, 0);
      end
      wait_cycles(HALF);
    end

    check("rx_data", {24'd0, rx[7:0]}, {24'd0, b});
    check("rx_parity", {31'd0, rx[8]}, {31'd0, par});
    check("odd_parity", {31'd0, ^rx[8:0]}, 1);
    check("rx_stop", {31'd0, rx[9]}, 1);

    // ACK clock: device drives data low (or not) before its 11th fall.
    dev_data = (mode == M_NACK);
    wait_cycles(4);
    dev_clk = 1'b0;
    n = 0;
    while (!(tx_if.done || tx_if.err) && n < 200) begin
      @(negedge clk);
      n++;
      if (n == HALF) dev_clk = 1'b1;
      if (n == HALF + 4) dev_data = 1'b1;
    end
    if (mode == M_NACK) begin
      check("nack_err", {31'd0, tx_if.err}, 1);
      check("nack_no_done", {31'd0, tx_if.done}, 0);
    end else begin
      check("ack_done", {31'd0, tx_if.done}, 1);
      check("ack_no_err", {31'd0, tx_if.err}, 0);
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
  endtask

  initial begin
    int d0, e0;
    tx_if.tx_data  = 8'h00;
    tx_if.tx_valid = 1'b0;
    rst = 1'b1;
    wait_cycles(3);
    check("reset_ready", {31'd0, tx_if.tx_ready}, 1);
    check("reset_busy", {31'd0, tx_if.busy}, 0);
    check("reset_done", {31'd0, tx_if.done}, 0);
    check("reset_err", {31'd0, tx_if.err}, 0);
    check("reset_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("reset_data_oe", {31'd0, ps2_data_oe}, 0);
    rst = 1'b0;
    wait_cycles(2);

    // Set-LEDs command, normal ACK
    send(PS2_CMD_SET_LEDS);
    device(8'hED, 1'b1, M_OK, 1'b0);

    // Parity corner cases
    send(8'h00);
    device(8'h00, 1'b1, M_OK, 1'b0);
    send(8'h01);
    device(8'h01, 1'b0, M_OK, 1'b0);

    // Device never clocks: timeout
    send(8'hF0);
    device(8'hF0, 1'b1, M_NOCLK, 1'b0);

    // Missing ACK, then a good reset command
    d0 = done_cnt;
    send(8'h55);
    device(8'h55, 1'b1, M_NACK, 1'b0);
    wait_cycles(2);
    check("nack_no_done_total", done_cnt - d0, 0);
    send(PS2_CMD_RESET);
    device(8'hFF, 1'b1, M_OK, 1'b0);

    // Reset mid-frame, then retry
    send(PS2_CMD_SET_LEDS);
    device(8'hED, 1'b1, M_RST, 1'b0);
    send(PS2_CMD_SET_LEDS);
    device(8'hED, 1'b1, M_OK, 1'b0);

    // Request held during a frame is only taken once the frame ends
    e0 = err_cnt;
    send(PS2_CMD_SET_LEDS);
    tx_if.tx_data  = 8'hAA;
    tx_if.tx_valid = 1'b1;
    device(8'hED, 1'b1, M_OK, 1'b0);
    device(8'hAA, 1'b1, M_OK, 1'b1);
    wait_cycles(5);
    check("final_idle", {31'd0, tx_if.tx_ready}, 1);
    check("final_no_err", err_cnt - e0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
